fetch_decode_queue: RTL

- Small instruction queue between the fetch stage and the decode stage of the LC-3b pipeline.
- Captures each valid fetched instruction word and its PC+2 when fetch asserts load_de.
- Presents the oldest entry to decode in show-ahead form.
- Absorbs decode back-pressure and is cleared on a branch or trap redirect.

---
 rtl/fetch_decode_queue.sv | 93 +++++++++
 1 files changed

// File: rtl/fetch_decode_queue.sv
// Show-ahead instruction queue between the LC-3b fetch and decode stages.
// Holds {IR, PC+2} pairs; flush on redirect, sticky flag on a dropped push.
module fetch_decode_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_valid,
    input  logic [15:0]      push_ir,
    input  logic [15:0]      push_pc,
    input  logic             pop,
    input  logic             flush,
    output logic [15:0]      out_ir,
    output logic [15:0]      out_pc,
    output logic             out_valid,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output logic             overflow_err
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [15:0]      ir_q [DEPTH];
    logic [15:0]      pc_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;

    logic pop_eff;
    logic push_eff;
    logic drop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign pop_eff  = pop & ~empty;
    assign push_eff = push & push_valid & (~full | pop_eff);
    assign drop     = push & push_valid & full & ~pop_eff & ~flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | drop;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({push_eff, pop_eff})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately left unreset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (!flush && push_eff) begin
            ir_q[wr_ptr_q] <= push_ir;
            pc_q[wr_ptr_q] <= push_pc;
        end
    end

    assign out_valid    = ~empty;
    assign out_ir       = empty ? 16'h0000 : ir_q[rd_ptr_q];
    assign out_pc       = empty ? 16'h0000 : pc_q[rd_ptr_q];
    assign count        = count_q;
    assign overflow_err = ovf_q;

endmodule
